// File: rtl/fir_out_requant.sv
// Requantizer behind the FIR core: shift the full-precision product sum back to
// OUT_W audio samples, with rounding, saturation and a 2-stage valid/ready pipeline.
module fir_out_requant #(
    parameter int IN_W  = 34,
    parameter int OUT_W = 16,
    parameter int SHIFT = 15,
    parameter int ROUND = 1
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             s_axis_data_tvalid,
    output logic             s_axis_data_tready,
    input  logic [IN_W-1:0]  s_axis_data_tdata,
    output logic             m_axis_data_tvalid,
    input  logic             m_axis_data_tready,
    output logic [OUT_W-1:0] m_axis_data_tdata,
    input  logic             clr_stats,
    output logic             sat_flag,
    output logic [15:0]      sat_count
);

    localparam int EXT_W = IN_W + 1;
    localparam int R_W   = EXT_W - SHIFT;

    // True when the shifted value does not fit in OUT_W signed bits.
    function automatic logic f_out_of_range(input logic [R_W-1:0] v);
        logic res;
        if ((&v[R_W-1:OUT_W-1]) || !(|v[R_W-1:OUT_W-1])) begin
            res = 1'b0;
        end else begin
            res = 1'b1;
        end
        return res;
    endfunction

    function automatic logic [OUT_W-1:0] f_sat(input logic [R_W-1:0] v);
        logic [OUT_W-1:0] res;
        if (!f_out_of_range(v)) begin
            res = v[OUT_W-1:0];
        end else if (v[R_W-1]) begin
            res = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            res = {1'b0, {(OUT_W-1){1'b1}}};
        end
        return res;
    endfunction

    logic             r_run;
    logic             r_v1;
    logic [R_W-1:0]   r_r1;
    logic             r_v2;
    logic [OUT_W-1:0] r_d2;
    logic             r_sat_flag;
    logic [15:0]      r_sat_count;

    logic             w_adv1;
    logic             w_adv2;
    logic             w_take;
    logic             w_sat_evt;
    logic [EXT_W-1:0] w_bias;
    logic [EXT_W-1:0] w_sum;
    logic [R_W-1:0]   w_r1;
    logic             w_unused_frac;

    // Rounding add on the sign-extended sample, stall/advance and saturation-event decode.
    always_comb begin
        w_bias = '0;
        if (ROUND != 0) begin
            w_bias[SHIFT-1] = 1'b1;
        end else begin
            w_bias = '0;
        end
        w_sum         = {s_axis_data_tdata[IN_W-1], s_axis_data_tdata} + w_bias;
        // Dropping the low SHIFT bits of a two's complement value is a floor shift.
        w_r1          = w_sum[EXT_W-1:SHIFT];
        w_unused_frac = ^w_sum[SHIFT-1:0];
        w_adv2        = ~r_v2 | m_axis_data_tready;
        w_adv1        = ~r_v1 | w_adv2;
        w_take        = s_axis_data_tvalid & w_adv1 & r_run;
        w_sat_evt     = w_adv2 & r_v1 & f_out_of_range(r_r1);
    end

    // Pipeline stages; stage 1 captures data only on a real transfer so idle tdata never enters state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_run <= 1'b0;
            r_v1  <= 1'b0;
            r_r1  <= '0;
            r_v2  <= 1'b0;
            r_d2  <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_adv1) begin
                r_v1 <= w_take;
                if (w_take) begin
                    r_r1 <= w_r1;
                end
            end
            if (w_adv2) begin
                r_v2 <= r_v1;
                r_d2 <= f_sat(r_r1);
            end
        end
    end

    // Saturation statistics; a clear beats a coincident event.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sat_flag  <= 1'b0;
            r_sat_count <= 16'd0;
        end else if (clr_stats) begin
            r_sat_flag  <= 1'b0;
            r_sat_count <= 16'd0;
        end else if (w_sat_evt) begin
            r_sat_flag <= 1'b1;
            if (r_sat_count != 16'hFFFF) begin
                r_sat_count <= r_sat_count + 16'd1;
            end
        end
    end

    assign s_axis_data_tready = w_adv1 & r_run;
    assign m_axis_data_tvalid = r_v2;
    assign m_axis_data_tdata  = r_d2;
    assign sat_flag           = r_sat_flag;
    assign sat_count          = r_sat_count;

endmodule

// File: tb/tb_fir_out_requant.sv
// Self-checking bench for fir_out_requant: behavioural scaling model with a scoreboard
// queue, randomized traffic and directed rounding/saturation/backpressure/reset cases.
module tb_fir_out_requant;

    localparam int IN_W  = 34;
    localparam int OUT_W = 16;
    localparam int SHIFT = 15;
    localparam int ROUND = 1;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic             s_tvalid = 1'b0;
    logic             s_tready;
    logic [IN_W-1:0]  s_tdata = '0;
    logic             m_tvalid;
    logic             m_ready = 1'b0;
    logic [OUT_W-1:0] m_tdata;
    logic             clr_stats = 1'b0;
    logic             sat_flag;
    logic [15:0]      sat_count;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     m_cnt = 0;
    bit     chk_lat = 1'b0;
    bit     rnd_mode = 1'b0;
    bit     prev_stall = 1'b0;
    logic [OUT_W-1:0] prev_data = '0;
    longint exp_q[$];
    int     stamp_q[$];
    longint got_q[$];
    longint stim_q[$];

    fir_out_requant #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .ROUND(ROUND)) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .s_axis_data_tvalid (s_tvalid),
        .s_axis_data_tready (s_tready),
        .s_axis_data_tdata  (s_tdata),
        .m_axis_data_tvalid (m_tvalid),
        .m_axis_data_tready (m_ready),
        .m_axis_data_tdata  (m_tdata),
        .clr_stats          (clr_stats),
        .sat_flag           (sat_flag),
        .sat_count          (sat_count)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    // Reference: divide by 2^SHIFT with round-half-up (floor of x/2^S + 1/2), then clamp.
    function automatic longint f_scale(input longint x);
        longint half;
        half = (ROUND != 0) ? (longint'(1) <<< (SHIFT - 1)) : longint'(0);
        return (x + half) >>> SHIFT;
    endfunction

    function automatic bit f_is_sat(input longint x);
        longint r;
        r = f_scale(x);
        return (r > 32767) || (r < -32768);
    endfunction

    function automatic longint f_model(input longint x);
        longint r;
        r = f_scale(x);
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: record accepted inputs, check every output transfer and stall stability.
    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (s_tvalid && s_tready) begin
                exp_q.push_back(f_model(longint'($signed(s_tdata))));
                stamp_q.push_back(cyc);
                if (f_is_sat(longint'($signed(s_tdata))) && m_cnt < 65535) m_cnt++;
            end
            if (prev_stall) begin
                chk("stall_valid", longint'(m_tvalid), 1);
                chk("stall_data", longint'($signed(m_tdata)), longint'($signed(prev_data)));
            end
            if (m_tvalid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0d expected none", $signed(m_tdata));
                end else begin
                    chk("data", longint'($signed(m_tdata)), exp_q.pop_front());
                    if (chk_lat) chk("latency", longint'(cyc - stamp_q[0]), 2);
                    void'(stamp_q.pop_front());
                    got_q.push_back(longint'($signed(m_tdata)));
                end
            end
            prev_stall = m_tvalid && !m_ready;
            prev_data  = m_tdata;
        end
    end

    task automatic send_all();
        int     i;
        int     guard;
        longint tmp;
        i = 0;
        guard = 0;
        while (i < stim_q.size() && guard < stim_q.size() * 8 + 100) begin
            @(posedge aclk);
            #1;
            guard++;
            if (rnd_mode) m_ready = ($urandom_range(0, 3) != 0);
            if (rnd_mode && $urandom_range(0, 3) == 0) begin
                s_tvalid = 1'b0;
                tmp = {$urandom, $urandom};
                s_tdata = tmp[IN_W-1:0];
                @(negedge aclk);
            end else begin
                s_tvalid = 1'b1;
                tmp = stim_q[i];
                s_tdata = tmp[IN_W-1:0];
                @(negedge aclk);
                if (s_tready) i++;
            end
        end
        if (i < stim_q.size()) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got %0d sent expected %0d", i, stim_q.size());
        end
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        s_tvalid = 1'b0;
        m_ready = 1'b1;
        while ((exp_q.size() != 0 || m_tvalid) && n < 30) begin
            @(negedge aclk);
            #1;
            n++;
        end
        if (n >= 30) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic clear_stats();
        @(posedge aclk);
        #1;
        clr_stats = 1'b1;
        @(posedge aclk);
        #1;
        clr_stats = 1'b0;
        m_cnt = 0;
    endtask

    task automatic chk_got(input string name, input longint lit[$]);
        chk({name, "_count"}, longint'(got_q.size()), longint'(lit.size()));
        for (int i = 0; i < lit.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_%0d", name, i), got_q[i], lit[i]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint tmp;
        bit     xfer;
        int     idx;

        repeat (3) @(negedge aclk);
        chk("rst_m_tvalid", longint'(m_tvalid), 0);
        chk("rst_m_tdata", longint'(m_tdata), 0);
        chk("rst_s_tready", longint'(s_tready), 0);
        chk("rst_sat_flag", longint'(sat_flag), 0);
        chk("rst_sat_count", longint'(sat_count), 0);
        #2 aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("release_tready", longint'(s_tready), 1);
        m_ready = 1'b1;

        // Rounding pins: each result exactly two cycles after its input.
        got_q.delete();
        stim_q = '{32768, 16384, 16383, -16384, -16385, 1073709056};
        chk_lat = 1'b1;
        send_all();
        drain();
        chk_lat = 1'b0;
        chk_got("round", '{1, 1, 0, 0, -1, 32767});
        chk("round_sat_count", longint'(sat_count), 0);
        chk("round_sat_flag", longint'(sat_flag), 0);

        // Saturation in both directions.
        clear_stats();
        got_q.delete();
        stim_q = '{(longint'(1) <<< 33) - 1, -(longint'(1) <<< 33), longint'(1) <<< 30};
        send_all();
        drain();
        chk_got("sat", '{32767, -32768, 32767});
        chk("sat_count3", longint'(sat_count), 3);
        chk("sat_flag1", longint'(sat_flag), 1);
        chk("sat_model", longint'(sat_count), longint'(m_cnt));

        // Clear coinciding with a saturation event: clear wins.
        @(posedge aclk);
        #1;
        s_tvalid = 1'b1;
        tmp = (longint'(1) <<< 33) - 1;
        s_tdata = tmp[IN_W-1:0];
        @(negedge aclk);
        chk("clr_tready", longint'(s_tready), 1);
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        clr_stats = 1'b1;
        @(posedge aclk);
        #1;
        clr_stats = 1'b0;
        @(negedge aclk);
        chk("clr_sat_count", longint'(sat_count), 0);
        chk("clr_sat_flag", longint'(sat_flag), 0);
        drain();
        m_cnt = 0;
        chk("clr_sat_count_after", longint'(sat_count), 0);

        // Backpressure: downstream stalled for cycles 3..7.
        got_q.delete();
        idx = 0;
        xfer = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge aclk);
            #1;
            if (xfer) idx++;
            s_tvalid = (idx < 5);
            tmp = longint'(idx + 1) <<< 15;
            s_tdata = tmp[IN_W-1:0];
            m_ready = !(c >= 3 && c <= 7);
            @(negedge aclk);
            xfer = s_tvalid && s_tready;
            if (c >= 3 && c <= 7) begin
                chk($sformatf("bp_tready_low_c%0d", c), longint'(s_tready), 0);
                chk($sformatf("bp_hold_c%0d", c), longint'($signed(m_tdata)), 1);
            end
            if (c == 8) chk("bp_tready_back", longint'(s_tready), 1);
        end
        drain();
        chk_got("bp", '{1, 2, 3, 4, 5});

        // Randomized traffic with bubbles and random downstream readiness.
        clear_stats();
        stim_q.delete();
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 2))
                0: tmp = {$urandom, $urandom};
                1: tmp = (longint'($urandom_range(0, 65535)) - 32768) * 32768 + 16383
                         + longint'($urandom_range(0, 2));
                2: tmp = (($urandom_range(0, 1) == 1) ? longint'(32767) : longint'(-32768)) * 32768
                         + longint'($urandom_range(0, 131071)) - 65536;
                default: tmp = 0;
            endcase
            stim_q.push_back(tmp);
        end
        rnd_mode = 1'b1;
        send_all();
        rnd_mode = 1'b0;
        drain();
        chk("rnd_sat_count", longint'(sat_count), longint'(m_cnt));
        chk("rnd_sat_flag", longint'(sat_flag), longint'(m_cnt != 0));

        // Counter ceiling: 65536 saturating samples.
        clear_stats();
        stim_q.delete();
        for (int i = 0; i < 65536; i++) stim_q.push_back((longint'(1) <<< 33) - 1);
        send_all();
        drain();
        chk("ceil_sat_count", longint'(sat_count), 65535);
        chk("ceil_sat_flag", longint'(sat_flag), 1);
        chk("ceil_model", longint'(sat_count), longint'(m_cnt));

        // Mid-stream reset with both stages full.
        @(posedge aclk);
        #1;
        s_tvalid = 1'b1;
        s_tdata = 34'd98304;
        @(posedge aclk);
        #1;
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        chk("pre_rst_valid", longint'(m_tvalid), 1);
        #2 aresetn = 1'b0;
        exp_q.delete();
        stamp_q.delete();
        m_cnt = 0;
        #1;
        chk("rst_async_valid", longint'(m_tvalid), 0);
        chk("rst_async_tready", longint'(s_tready), 0);
        @(posedge aclk);
        #3 aresetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            chk($sformatf("no_stale_%0d", i), longint'(m_tvalid), 0);
        end
        chk("post_rst_sat_count", longint'(sat_count), 0);
        chk("post_rst_tready", longint'(s_tready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_out_requant.md
Name: fir_out_requant

Overview:
Requantizer stage directly downstream of the FIR core (core_m). It accepts the 34-bit full-precision FIR output and scales it back to 16-bit audio samples by dropping the Q15 coefficient fraction. Scaling is an arithmetic right shift with round-half-up, followed by saturation. It provides AXI-stream style valid/ready on both sides, a 2-stage pipeline with backpressure, and saturation statistics for the audio denoise chain.

Parameters:
IN_W, 34, input sample width (signed two's complement)
OUT_W, 16, output sample width (signed two's complement)
SHIFT, 15, right-shift amount (coefficient fraction bits); legal range 1..IN_W-OUT_W
ROUND, 1, 1 = round half up (add 2^(SHIFT-1) before the shift); 0 = truncate (floor)

Ports:
aclk  in  1  clock; all logic on the rising edge
aresetn  in  1  asynchronous active-low reset
s_axis_data_tvalid  in  1  upstream sample valid
s_axis_data_tready  out  1  this block can accept a sample this cycle
s_axis_data_tdata  in  IN_W  signed FIR output sample
m_axis_data_tvalid  out  1  output sample valid
m_axis_data_tready  in  1  downstream ready
m_axis_data_tdata  out  OUT_W  signed requantized sample
clr_stats  in  1  synchronous clear of sat_flag and sat_count
sat_flag  out  1  sticky: at least one sample saturated since reset or clear
sat_count  out  16  number of saturated samples; holds at 65535

Behaviour:
- Reset (aresetn=0, asynchronous) clears all registers immediately. Outputs after reset:
  - m_axis_data_tvalid=0, m_axis_data_tdata=0
  - s_axis_data_tready=0 while reset is asserted; 1 from the first cycle after release
  - sat_flag=0, sat_count=0
- Reset asserted mid-stream discards all in-flight samples. No partial output is produced.
- Transfer rule: a transfer occurs on any edge where tvalid=1 and tready=1 on that interface.
- Pipeline registers: stage 1 (v1, r1) and stage 2 (v2, d2). Stage 2 drives m_axis_data_tvalid=v2 and m_axis_data_tdata=d2.
- Stall and advance logic:
  - adv2 = ~v2 | m_axis_data_tready
  - adv1 = ~v1 | adv2
  - s_axis_data_tready = adv1. This is combinational from m_axis_data_tready and has no other combinational path.
- Stage 1 (loads when adv1):
  - r1 = (sx + ROUND*2^(SHIFT-1)) >>> SHIFT, where sx is s_axis_data_tdata sign-extended to IN_W+1 bits so the rounding add cannot overflow.
  - v1 = s_axis_data_tvalid & adv1.
- Stage 2 (loads when adv2):
  - d2 = sat(r1), where sat clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - v2 = v1.
- Latency and throughput:
  - Latency is 2 cycles from input transfer to m_axis_data_tvalid, with no stalls.
  - Throughput is 1 sample per cycle.
- Backpressure:
  - While m_axis_data_tready=0 and v2=1, d2 holds stable.
  - The pipeline absorbs at most 1 further sample (stage 1). After that, s_axis_data_tready drops.
  - No sample is lost or duplicated, and order is preserved.
- Saturation event: the cycle in which stage 2 loads a valid sample whose r1 lies outside the output range.
  - On an event, sat_flag is set to 1.
  - On an event, sat_count increments by 1 unless it is already 65535, in which case it holds.
- clr_stats=1 clears sat_flag and sat_count to 0. If it coincides with a saturation event, the clear wins (both read 0 next cycle).
- Bubbles (v1=0) never generate saturation events, even if r1 holds out-of-range stale data.
- No internal state depends on tdata when tvalid=0. X on tdata with tvalid=0 must not propagate to any output.

Test Plan:
- Reset release, SHIFT=15, ROUND=1: all outputs 0 during reset, s_axis_data_tready=1 the cycle after release.
- Scaling and rounding, one sample per cycle with m_axis_data_tready=1. Each result appears exactly 2 cycles after its input:
  - 32768 -> 1
  - 16384 -> 1
  - 16383 -> 0
  - -16384 -> 0
  - -16385 -> -1
  - 1073709056 -> 32767 (no saturation)
- Saturation and stats:
  - Inputs 2^33-1, then -2^33, then 1073741824 -> outputs 32767, -32768, 32767; sat_count=3, sat_flag=1.
  - Then pulse clr_stats coincident with another saturating sample -> sat_count=0, sat_flag=0.
- Backpressure:
  - Stream 1,2,3,4,5 (scaled by 2^15) with s_axis_data_tvalid held high; hold m_axis_data_tready=0 for cycles 3-7.
  - Required: s_axis_data_tready low from the cycle after the second transfer until m_axis_data_tready rises.
  - Required: m_axis_data_tdata stable at 1 while stalled; outputs 1,2,3,4,5 in order with none lost.
- Counter ceiling: force 65536 saturating samples -> sat_count holds at 65535 and does not wrap.
- Mid-stream reset: assert aresetn=0 for 1 cycle while v1=v2=1 -> m_axis_data_tvalid=0 immediately (asynchronous), and no stale sample is emitted after release.
